sc_dot_product_ctrl: RTL and testbench
======================================

// Module: sc_dot_product_ctrl
// PURPOSE
//   Sequencer for one stochastic dot-product evaluation. It runs the bitstream generators for a
//   programmed stream length and drives the adder select lines. It then counts the 1s in the
//   dot-product result stream, which converts it back to binary, and reports the count with a
//   done pulse. It sits between the host/control logic and the dot-product datapath and its
//   SNG/select sources.
// PARAMETERS
//   LENGTH        4    vector length of the controlled dot product; power of two, >= 2
//   SELECT_WIDTH  2    clogb2(LENGTH); width of adder select bus
//   CNT_W         8    width of stream_len and count_out; max stream length 2^CNT_W-1
//   PIPE_LATENCY  2    cycles from stream_en-qualified input to matching dp_result bit
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous, active-high reset
//   start      in   1             request one evaluation; sampled only in IDLE
//   stream_len in   CNT_W         bitstream length in cycles; captured when start is accepted
//   busy       out  1             high in RUN, DRAIN and DONE
//   stream_en  out  1             enables data/weight SNGs; high exactly stream_len cycles
//   sel        out  SELECT_WIDTH  adder select stream, uniform over 0..LENGTH-1
//   dp_result  in   1             result bitstream from the dot-product datapath
//   count_out  out  CNT_W         number of 1s observed in the result window
//   done       out  1             one-cycle pulse; count_out is valid from this cycle
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, stream_en=0, done=0, count_out=0, sel=0; counters cleared.
//     With SC_DOT_CTRL_LFSR_EN defined, the LFSR is set to seed 16'hACE1 instead.
//   FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE: on the edge where start=1, capture len=stream_len, clear count, zero the cycle counter.
//     If len!=0, go to RUN. If len==0, go to DONE (count_out=0).
//   RUN: stream_en=1. Leave after exactly len cycles and enter DRAIN.
//   DRAIN: stream_en=0. Lasts exactly PIPE_LATENCY cycles, then enter DONE.
//   DONE: done=1 for one cycle, then return to IDLE. start is not accepted in DONE.
//   Accumulate window: a PIPE_LATENCY-deep shift of stream_en (en_d) is cleared on reset.
//     count increments when en_d[PIPE_LATENCY-1]=1 and dp_result=1.
//     The window is exactly len cycles, offset by PIPE_LATENCY.
//   Latency: start accepted at edge E0 -> done high in cycle E0+1+len+PIPE_LATENCY (len>0).
//   count_out: updates live during the window. Final at done; held until the next start is accepted.
//   No overflow: count <= len <= 2^CNT_W-1, so saturation is not required.
//   sel: advances every cycle while stream_en or en_d is high; holds its value otherwise.
//   start while busy: ignored; no queueing. stream_len changes after acceptance: no effect.
//   Reset mid-operation: immediate return to the reset state. No done pulse; the partial count
//     is discarded.
// CONFIGURATION
//   SC_DOT_CTRL_LFSR_EN defined:
//     sel = low SELECT_WIDTH bits of a 16-bit maximal Fibonacci LFSR
//       (taps 16,14,13,11; seed 16'hACE1).
//     The LFSR is not reseeded per run, which decorrelates successive evaluations.
//   SC_DOT_CTRL_LFSR_EN undefined:
//     sel = SELECT_WIDTH-bit binary up-counter, cleared to 0 when start is accepted.
//     Gives exact uniform selection when len is a multiple of LENGTH.
// TESTING
//   1 Assert rst mid-cycle with no clock -> all outputs 0 immediately; state IDLE.
//   2 len=8, dp_result=1 constant -> stream_en high for 8 cycles.
//     done in cycle E0+11; count_out=8; busy low the next cycle.
//   3 len=16, dp_result toggling 1/0 aligned to the window -> count_out=8.
//     Bits outside the window (before/after) are ignored.
//   4 start pulsed during RUN of a len=8 job -> ignored: one done, count_out=8.
//     len=0 -> done in cycle E0+1; count_out=0; stream_en never high.
//   5 rst asserted at cycle 4 of RUN (len=20) -> no done; count_out=0.
//     A new start with len=4 and dp_result=1 -> count_out=4.
//   6 Macro off, LENGTH=4, len=8 -> sel sequence 0,1,2,3,0,1,2,3,... over window.
//     Macro on -> sel equals LFSR low bits, with first value from seed 16'hACE1.

Source files
------------

// File: rtl/sc_dot_product_ctrl_if.sv
// sc_dot_product_ctrl_if
//   Handshake and data bundle between the host/datapath side and the
//   stochastic dot-product sequencer.
//   master : host side. Drives start, stream_len and dp_result; observes the status outputs.
//   slave  : sequencer side. Drives busy, stream_en, sel, count_out and done.
interface sc_dot_product_ctrl_if #(
  parameter int SELECT_WIDTH = 2,
  parameter int CNT_W        = 8
);
  logic                    start;
  logic [CNT_W-1:0]        stream_len;
  logic                    busy;
  logic                    stream_en;
  logic [SELECT_WIDTH-1:0] sel;
  logic                    dp_result;
  logic [CNT_W-1:0]        count_out;
  logic                    done;

  modport master (output start, stream_len, dp_result,
                  input  busy, stream_en, sel, count_out, done);
  modport slave  (input  start, stream_len, dp_result,
                  output busy, stream_en, sel, count_out, done);
endinterface

// File: rtl/sc_dot_product_ctrl.sv
// sc_dot_product_ctrl
//   Sequencer for one stochastic dot-product evaluation. It enables the SNGs
//   for stream_len cycles and drives the adder select stream. It counts the 1s
//   of the result stream over a window that is delayed by PIPE_LATENCY, then
//   pulses done with the final count.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : sc_dot_product_ctrl_if.slave carrying
//            start, stream_len, dp_result (in) and busy, stream_en, sel,
//            count_out, done (out)
//   Configuration macro: SC_DOT_CTRL_LFSR_EN selects a 16-bit LFSR as the
//   sel source. When the macro is undefined, a modulo-LENGTH up-counter is
//   used and is cleared on each start.
module sc_dot_product_ctrl #(
  parameter int LENGTH       = 4,
  parameter int SELECT_WIDTH = 2,
  parameter int CNT_W        = 8,
  parameter int PIPE_LATENCY = 2
) (
  input logic                  clk,
  input logic                  rst,
  sc_dot_product_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        len_q, cyc_q, count_q;
  logic                    busy_q, stream_en_q, done_q;
  logic [PIPE_LATENCY-1:0] en_d_q;
  logic                    accept, sel_adv;

  assign accept  = (state_q == IDLE) && bus.start;
  // sel keeps moving until the last in-flight bit leaves the datapath
  assign sel_adv = stream_en_q | (|en_d_q);

  // Control FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cyc_q       <= '0;
      busy_q      <= 1'b0;
      stream_en_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          len_q  <= bus.stream_len;
          cyc_q  <= '0;
          busy_q <= 1'b1;
          if (bus.stream_len != '0) begin
            state_q     <= RUN;
            stream_en_q <= 1'b1;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        RUN: if (cyc_q == len_q - 1'b1) begin
          state_q     <= DRAIN;
          stream_en_q <= 1'b0;
          cyc_q       <= '0;
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
        DRAIN: if (cyc_q == CNT_W'(PIPE_LATENCY - 1)) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          cyc_q   <= '0;
        end else begin
          cyc_q <= cyc_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The delayed enable marks the cycles whose dp_result bit belongs to this run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d_q  <= '0;
      count_q <= '0;
    end else begin
      en_d_q[0] <= stream_en_q;
      for (int i = 1; i < PIPE_LATENCY; i++) en_d_q[i] <= en_d_q[i-1];
      if (accept)                                        count_q <= '0;
      else if (en_d_q[PIPE_LATENCY-1] && bus.dp_result)  count_q <= count_q + 1'b1;
    end
  end

`ifdef SC_DOT_CTRL_LFSR_EN
  // Fibonacci LFSR, taps 16,14,13,11. It is never reseeded, so successive
  // runs continue the sequence.
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lfsr_q <= 16'hACE1;
    else if (sel_adv) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign bus.sel = lfsr_q[SELECT_WIDTH-1:0];
`else
  logic [SELECT_WIDTH-1:0] sel_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sel_q <= '0;
    else if (accept)  sel_q <= '0;
    else if (sel_adv) sel_q <= (sel_q == SELECT_WIDTH'(LENGTH - 1)) ? '0 : sel_q + 1'b1;
  end
  assign bus.sel = sel_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.stream_en = stream_en_q;
  assign bus.done      = done_q;
  assign bus.count_out = count_q;
endmodule

// File: tb/tb_sc_dot_product_ctrl.sv
module tb_sc_dot_product_ctrl;
  localparam int LENGTH = 4;
  localparam int SW     = 2;
  localparam int CNT_W  = 8;
  localparam int PL     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sc_dot_product_ctrl_if #(.SELECT_WIDTH(SW), .CNT_W(CNT_W)) bus ();

  sc_dot_product_ctrl #(.LENGTH(LENGTH), .SELECT_WIDTH(SW), .CNT_W(CNT_W), .PIPE_LATENCY(PL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] lfsr_m = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sel after a given number of advances since the run started.
  function automatic logic [31:0] exp_sel(input int steps);
`ifdef SC_DOT_CTRL_LFSR_EN
    logic [15:0] s;
    s = lfsr_m;
    for (int k = 0; k < steps; k++) s = lfsr_step(s);
    return 32'(s[SW-1:0]);
`else
    return 32'(steps % LENGTH);
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_en"},    32'(bus.stream_en), 0);
    chk({tag, "_done"},  32'(bus.done), 0);
    chk({tag, "_count"}, 32'(bus.count_out), 0);
`ifdef SC_DOT_CTRL_LFSR_EN
    chk({tag, "_sel"},   32'(bus.sel), 32'h1);
`else
    chk({tag, "_sel"},   32'(bus.sel), 0);
`endif
  endtask

  // pat: 0 all ones, 1 random, 2 alternating 1/0 in the window with ones outside.
  // kick: cycle index for an extra start pulse (0 = none).
  // abort_at: cycle index for a mid-cycle reset (0 = none).
  task automatic run_job(input int len, input int pat, input int kick, input int abort_at);
    bit bits [0:511];
    int exp_cnt, done_t, steps;
    exp_cnt = 0;
    done_t  = (len == 0) ? 1 : len + PL + 1;
    for (int i = 0; i < 512; i++) begin
      case (pat)
        0:       bits[i] = 1'b1;
        1:       bits[i] = 1'($urandom_range(0, 1));
        default: bits[i] = (i >= 1 + PL && i <= len + PL) ? ((i - PL - 1) % 2 == 0) : 1'b1;
      endcase
      if (i >= 1 + PL && i <= len + PL && bits[i]) exp_cnt++;
    end
    @(negedge clk);
    bus.start = 1'b1; bus.stream_len = CNT_W'(len); bus.dp_result = bits[0];
    @(posedge clk); #1;
    bus.stream_len = CNT_W'($urandom);
    for (int t = 1; t <= done_t + 3; t++) begin
      bus.dp_result = bits[t];
      bus.start     = (t == kick);
      if (abort_at != 0 && t == abort_at) begin
        bus.start = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_outputs("abort_async");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        lfsr_m = 16'hACE1;
        for (int k = 0; k < len + PL + 4; k++) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(bus.done), 0);
        end
        chk("abort_count", 32'(bus.count_out), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        return;
      end
      steps = (len == 0) ? 0 : ((t - 1 < len + PL) ? t - 1 : len + PL);
      chk($sformatf("en_l%0d_t%0d", len, t),   32'(bus.stream_en), 32'(t <= len));
      chk($sformatf("busy_l%0d_t%0d", len, t), 32'(bus.busy), 32'(t <= done_t));
      chk($sformatf("done_l%0d_t%0d", len, t), 32'(bus.done), 32'(t == done_t));
      chk($sformatf("sel_l%0d_t%0d", len, t),  32'(bus.sel), exp_sel(steps));
      if (t >= done_t) chk($sformatf("count_l%0d_t%0d", len, t), 32'(bus.count_out), 32'(exp_cnt));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    if (len != 0) for (int k = 0; k < len + PL; k++) lfsr_m = lfsr_step(lfsr_m);
  endtask

  initial begin
    bus.start = 1'b0; bus.stream_len = '0; bus.dp_result = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("por");
    @(negedge clk) rst = 1'b0;
    run_job(8, 0, 0, 0);
    run_job(16, 2, 0, 0);
    run_job(8, 0, 3, 0);
    run_job(0, 1, 0, 0);
    run_job(20, 1, 0, 4);
    run_job(4, 0, 0, 0);
    run_job(1, 0, 0, 0);
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 40), 1, 0, 0);
    run_job(255, 1, 0, 0);
    run_job(5, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
